// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared FSM state encodings for the sequential divider
// Contents: S_IDLE, S_RUN, S_DONE state constants used by seq_divider.
package seq_divider_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_step.sv
// rtl/seq_divider_step.sv - one combinational restoring-division step
// Ports:
//   r       in   VW  current partial remainder
//   q_msb   in   1   dividend/quotient bit shifted into the remainder
//   d       in   VW  divisor
//   r_next  out  VW  partial remainder after the step
//   q_bit   out  1   quotient bit produced by the step
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int VW = 4
) (
    input  logic [VW-1:0] r,
    input  logic          q_msb,
    input  logic [VW-1:0] d,
    output logic [VW-1:0] r_next,
    output logic          q_bit
);

    logic [VW:0] t;

    // T needs VW+1 bits; the restored/subtracted result always fits back in VW
    // bits whenever d != 0, and for d == 0 only the low VW bits are meaningful.
    always_comb begin
        t      = {r, q_msb};
        q_bit  = (t >= {1'b0, d});
        r_next = q_bit ? VW'(t - {1'b0, d}) : t[VW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
// Optional feature macro: DIV_ZERO_DETECT_EN (divisor 0 short-cuts straight to DONE, flags div_zero).
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   start      in   1   request, accepted in IDLE or DONE
//   dividend   in   DW  captured on accepted start
//   divisor    in   VW  captured on accepted start
//   busy       out  1   high while running
//   done       out  1   one-cycle result-valid pulse
//   quotient   out  DW  result, held until the next result
//   remainder  out  VW  result, held until the next result
//   div_zero   out  1   divisor was zero (feature build only, else 0)
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_zero
);

    localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

    logic [1:0]       state_q,     state_d;
    logic [VW-1:0]    prem_q,      prem_d;
    logic [DW-1:0]    qreg_q,      qreg_d;
    logic [VW-1:0]    dvs_q,       dvs_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [DW-1:0]    quotient_q,  quotient_d;
    logic [VW-1:0]    remainder_q, remainder_d;
`ifdef DIV_ZERO_DETECT_EN
    logic             div_zero_q,  div_zero_d;
`endif

    logic [VW-1:0]    step_r;
    logic             step_q;

    seq_divider_step #(.VW(VW)) u_step (
        .r      (prem_q),
        .q_msb  (qreg_q[DW-1]),
        .d      (dvs_q),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    always_comb begin
        state_d     = state_q;
        prem_d      = prem_q;
        qreg_d      = qreg_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
        div_zero_d  = div_zero_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor == '0) begin
                        // Result is known immediately; present it next cycle.
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend[VW-1:0];
                        div_zero_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        prem_d  = '0;
                        qreg_d  = dividend;
                        dvs_d   = divisor;
                        cnt_d   = '0;
                    end
`else
                    state_d = S_RUN;
                    prem_d  = '0;
                    qreg_d  = dividend;
                    dvs_d   = divisor;
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // Q doubles as the dividend shift register: its msb feeds the
                // step while the new quotient bit enters at the lsb.
                prem_d = step_r;
                qreg_d = {qreg_q[DW-2:0], step_q};
                if (cnt_q == CNT_W'(DW - 1)) begin
                    state_d     = S_DONE;
                    quotient_d  = {qreg_q[DW-2:0], step_q};
                    remainder_d = step_r;
`ifdef DIV_ZERO_DETECT_EN
                    div_zero_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prem_q      <= '0;
            qreg_q      <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            prem_q      <= prem_d;
            qreg_q      <= qreg_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
`ifdef DIV_ZERO_DETECT_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_DETECT_EN
    assign div_zero  = div_zero_q;
`else
    assign div_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_zero;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
        int         due;
        int         busy;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   asserts  = 0;
    int   fails    = 0;
    int   n_start  = 0;

    seq_divider #(.DW(8), .VW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation every time done is seen.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL spurious_done: got done=1 expected no result (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("div_zero", div_zero, e.dz);
                    check("done_cycle", cyc, e.due);
                    check("busy_cycles", busy_cnt, e.busy);
                end
                busy_cnt = 0;
            end
        end
    end

    function automatic exp_t mk(input logic [7:0] q, input logic [3:0] r,
                                input logic zero_case, input int base);
        exp_t e;
        e.q = q; e.r = r; e.dz = 1'b0; e.due = base + 9; e.busy = 8;
`ifdef DIV_ZERO_DETECT_EN
        if (zero_case) begin
            e.dz = 1'b1; e.due = base + 1; e.busy = 0;
        end
`else
        if (zero_case) e.dz = 1'b0;
`endif
        return e;
    endfunction

    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic zero_case);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        n_start = cyc;
        sb.push_back(mk(eq, er, zero_case, cyc));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            asserts++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_div_zero", div_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);   wait_drain();
        issue(8'd255, 4'd15, 8'd17, 4'd0, 1'b0);  wait_drain();
        issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0);      wait_drain();
        issue(8'd0, 4'd1, 8'd0, 4'd0, 1'b0);      wait_drain();
        issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);  wait_drain();
        issue(8'd1, 4'd15, 8'd0, 4'd1, 1'b0);     wait_drain();
        issue(8'hA5, 4'd0, 8'hFF, 4'd5, 1'b1);    wait_drain();

        // Operand change and start pulse mid-run must be ignored.
        issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
        @(negedge clk); @(negedge clk);
        dividend = 8'd255; divisor = 4'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // start held high through DONE: second op accepted back-to-back.
        @(negedge clk);
        dividend = 8'd200; divisor = 4'd7; start = 1'b1;
        n_start = cyc;
        sb.push_back(mk(8'd28, 4'd4, 1'b0, n_start));
        sb.push_back(mk(8'd4, 4'd1, 1'b0, n_start + 9));
        @(negedge clk);
        dividend = 8'd9; divisor = 4'd2;
        while (cyc < n_start + 10) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset mid-run aborts without a done pulse.
        @(negedge clk);
        dividend = 8'd50; divisor = 4'd5; start = 1'b1;
        n_start = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n_start + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        issue(8'd0, 4'd1, 8'd0, 4'd0, 1'b0);      wait_drain();
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);   wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
